// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, fetch FSM states and reset PC.
package cpu_pkg;

  localparam int WORD_W = 16;

  localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_UPDATE,
    ST_HOLD,
    ST_FLUSH,
    ST_ERR
  } fetch_state_e;

endpackage

// File: rtl/fetch_wait_timer.sv
// Counts memory wait cycles for one outstanding read and flags when the read has waited too long.
module fetch_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (tick && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the tick that brings the count up to TIMEOUT, so the FSM leaves after exactly TIMEOUT waits.
  assign expired = (TIMEOUT != 0) && tick && (cnt_q >= LIMIT);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one read per PC, hands back the word and the next PC, handles redirects.
module fetch_unit #(
  parameter int WORD_W  = cpu_pkg::WORD_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] pc,
  output logic [WORD_W-1:0] in_pc,
  output logic              en_pc,
  output logic [WORD_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [WORD_W-1:0] br_target,
  output logic [WORD_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_err
);
  import cpu_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] in_pc_q, in_pc_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              en_pc_q, en_pc_d;
  logic              ivld_q, ivld_d;
  logic              err_q, err_d;
  logic              tmr_clear, tmr_tick, tmr_expired;

  assign mem_rd = (state_q == ST_WAIT) || (state_q == ST_FLUSH);

  always_comb begin
    state_d = state_q;
    in_pc_d = in_pc_q;
    addr_d  = addr_q;
    instr_d = instr_q;
    en_pc_d = 1'b0;
    ivld_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (br_taken) begin
          en_pc_d = 1'b1;
          in_pc_d = br_target;
          state_d = ST_UPDATE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (br_taken) begin
          en_pc_d = 1'b1;
          in_pc_d = br_target;
          state_d = ST_UPDATE;
        end else begin
          addr_d  = pc;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (br_taken) begin
          // Redirect wins; a read still in flight must be drained in FLUSH.
          en_pc_d = 1'b1;
          in_pc_d = br_target;
          state_d = mem_ready ? ST_UPDATE : ST_FLUSH;
        end else if (mem_ready) begin
          instr_d = mem_rdata;
          ivld_d  = 1'b1;
          en_pc_d = 1'b1;
          in_pc_d = addr_q + WORD_W'(1);
          state_d = ST_UPDATE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_UPDATE, ST_HOLD: begin
        if (br_taken) begin
          en_pc_d = 1'b1;
          in_pc_d = br_target;
          state_d = ST_UPDATE;
        end else begin
          state_d = stall ? ST_HOLD : ST_ISSUE;
        end
      end
      ST_FLUSH: begin
        if (br_taken) begin
          en_pc_d = 1'b1;
          in_pc_d = br_target;
          state_d = mem_ready ? ST_UPDATE : ST_FLUSH;
        end else if (mem_ready) begin
          state_d = ST_ISSUE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_ERR;
        end
      end
      ST_ERR: state_d = ST_ERR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      in_pc_q <= WORD_W'(RESET_PC);
      addr_q  <= '0;
      instr_q <= '0;
      en_pc_q <= 1'b0;
      ivld_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      in_pc_q <= in_pc_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      en_pc_q <= en_pc_d;
      ivld_q  <= ivld_d;
      err_q   <= err_d;
    end
  end

  assign tmr_clear = (state_d != state_q) && ((state_d == ST_WAIT) || (state_d == ST_FLUSH));
  assign tmr_tick  = mem_rd && !mem_ready;

  fetch_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  assign in_pc       = in_pc_q;
  assign en_pc       = en_pc_q;
  assign mem_addr    = addr_q;
  assign instr       = instr_q;
  assign instr_valid = ivld_q;
  assign fetch_err   = err_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter WORD_W, default 16, sets the data and address width.
REQ-002 Parameter TIMEOUT, default 15, gives the maximum wait cycles per memory read; 0 disables the timeout.
REQ-003 clk  in  1  system clock; all state changes on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 pc  in  16  current program counter, from the PC register output.
REQ-006 in_pc  out  16  next PC value, to the PC register load input.
REQ-007 en_pc  out  1  PC load enable, a one-cycle pulse.
REQ-008 mem_addr  out  16  instruction memory read address.
REQ-009 mem_rd  out  1  read request, held high until mem_ready is sampled.
REQ-010 mem_rdata  in  16  instruction memory read data, valid when mem_ready=1.
REQ-011 mem_ready  in  1  read completion strobe.
REQ-012 stall  in  1  downstream hold request.
REQ-013 br_taken  in  1  redirect request, one-cycle pulse.
REQ-014 br_target  in  16  redirect address, valid with br_taken.
REQ-015 instr  out  16  last fetched instruction, held between captures.
REQ-016 instr_valid  out  1  one-cycle pulse marking a new instr.
REQ-017 fetch_err  out  1  sticky memory-timeout flag.

Function
REQ-018 States SHALL be IDLE, ISSUE, WAIT, UPDATE, HOLD, FLUSH and ERR; all outputs except mem_rd SHALL be registered.
REQ-019 mem_rd SHALL be high exactly when the state is WAIT or FLUSH.
REQ-020 IDLE SHALL go to ISSUE on the first cycle after reset deasserts.
REQ-021 ISSUE SHALL latch mem_addr<=pc and go to WAIT, lasting exactly one cycle.
REQ-022 In WAIT, when mem_ready=1 the block SHALL set instr<=mem_rdata, instr_valid<=1, en_pc<=1 and in_pc<=mem_addr+1, then go to UPDATE.
REQ-023 The in_pc increment SHALL wrap modulo 2^16, so 0xFFFF yields 0x0000.
REQ-024 UPDATE SHALL clear en_pc and instr_valid, then go to HOLD if stall=1, else to ISSUE.
REQ-025 HOLD SHALL remain while stall=1 and go to ISSUE on the first cycle stall=0.
REQ-026 Minimum fetch period SHALL be 3 cycles (ISSUE, WAIT, UPDATE) when mem_ready answers in the first WAIT cycle.
REQ-027 stall SHALL NOT abort a read in WAIT; it is only evaluated in UPDATE and HOLD.
REQ-028 br_taken in IDLE, ISSUE, UPDATE or HOLD SHALL set en_pc<=1 and in_pc<=br_target, suppress instr_valid and go to UPDATE.
REQ-029 br_taken in WAIT with mem_ready=0 SHALL pulse en_pc with br_target and go to FLUSH.
REQ-030 br_taken in WAIT with mem_ready=1 SHALL pulse en_pc with br_target, discard mem_rdata (instr unchanged, instr_valid=0) and go to UPDATE.
REQ-031 FLUSH SHALL discard data on mem_ready and then go to ISSUE.
REQ-032 br_taken in FLUSH SHALL pulse en_pc with the new br_target and stay in FLUSH.
REQ-033 br_taken SHALL have priority over stall, and the latest br_target SHALL win.
REQ-034 A wait counter SHALL clear on entry to WAIT or FLUSH and increment each cycle mem_ready=0.
REQ-035 If TIMEOUT is nonzero and the wait counter reaches TIMEOUT, the block SHALL go to ERR and set fetch_err=1.
REQ-036 ERR SHALL hold mem_rd=0, en_pc=0 and instr_valid=0, ignore all inputs and exit only on reset.

Reset
REQ-037 While reset=0 at a clock edge, the block SHALL set state=IDLE, in_pc=0, en_pc=0, mem_addr=0, instr=0, instr_valid=0, fetch_err=0 and wait counter=0.
REQ-038 Reset during WAIT or FLUSH SHALL drop mem_rd after that edge, and the late mem_ready SHALL be ignored.

Structure
REQ-039 Shared package cpu_pkg SHALL hold WORD_W, the fetch state enumeration and the reset PC constant (0x0000).
REQ-040 The wait counter and timeout compare SHALL be sub-module fetch_wait_timer (inputs clear and tick, output expired).

Verification
REQ-041 Zero-wait memory from reset, with pc following in_pc: mem_addr SHALL be 0x0000, 0x0001, 0x0002 at a 3-cycle period, with instr_valid each period.
REQ-042 mem_ready 4 cycles late at pc=0x0010: exactly one instr_valid SHALL occur, with in_pc=0x0011 and no extra en_pc.
REQ-043 br_taken with br_target=0x0100 during WAIT, mem_ready 2 cycles later: that data SHALL be discarded and the next mem_addr SHALL be 0x0100.
REQ-044 pc=0xFFFF, then stall=1 for 5 cycles after capture: in_pc SHALL be 0x0000, the block SHALL stay in HOLD with no mem_rd, then ISSUE at address 0x0000.
REQ-045 TIMEOUT=15 with mem_ready held low: fetch_err SHALL be 1 after 15 WAIT cycles with mem_rd=0, and reset SHALL clear it and restart at 0x0000.
